dense_layer_sequencer: RTL and testbench
========================================

# dense_layer_sequencer

Sequences one fully-connected layer over the single-port 24-bit inference RAM: for each output neuron it reads the bias, walks the input vector and weight row, accumulates signed products, requantizes, and writes the result back into the RAM. Firmware runs it once per layer (W1/b1 → H, then W2/b2 → Y) by reprogramming the base addresses and sizes at `start`. It is the sole RAM master while `busy` is high.

## Interface
- `ADDRESS_WIDTH`, 14: RAM address width; all address arithmetic wraps modulo 2^ADDRESS_WIDTH.
- `DATA_WIDTH`, 24: RAM word width; operands and results are signed two's complement.
- `CNT_WIDTH`, 16: width of `n_in` / `n_out`.
- `ACC_WIDTH`, 58: accumulator width, 2*DATA_WIDTH+10; the accumulator wraps on overflow.
- `OUT_SHIFT`, 0: arithmetic right shift applied to the accumulator before saturation.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request; sampled only in IDLE.
- `x_base`, `w_base`, `b_base`, `out_base` in ADDRESS_WIDTH each: layer base addresses, latched at accepted `start`.
- `n_in`, `n_out` in CNT_WIDTH each: inputs per neuron and neuron count, latched at accepted `start`.
- `busy` out 1: high from the cycle after an accepted `start` through DONE.
- `done` out 1: one-cycle pulse at completion.
- `ram_en` out 1, `ram_we` out 4, `ram_addr` out ADDRESS_WIDTH, `ram_wdata` out DATA_WIDTH: RAM command, with reads using `ram_we=0` and writes using `ram_we=4'hF`.
- `ram_rdata` in DATA_WIDTH: RAM read data, valid the cycle after a read is issued.

## Operation
- Bias, weight and x reads all go through `ram_rdata`. The x operand is used exactly as returned: pixel reads already arrive zero-extended, so they are non-negative.
- States: IDLE, B_RD, B_CAP, X_RD, W_RD, MAC, WR, DONE.
- **IDLE**
  - `start=1` with `n_out=0` goes to DONE.
  - `start=1` otherwise latches all config, clears neuron index `n` and input index `i`, and goes to B_RD.
- **B_RD**: read `b_base+n` → B_CAP.
- **B_CAP**: acc ← sign-extended `ram_rdata`. Go to WR if `n_in=0`, else to X_RD.
- **X_RD**: read the x pointer (starts at `x_base` per neuron) → W_RD.
- **W_RD**: x_reg ← `ram_rdata`; read the w pointer (starts at `w_base` at `start` and runs continuously across neurons) → MAC.
- **MAC**: acc ← acc + signed(x_reg)*signed(`ram_rdata`); increment both pointers. Go to WR if `i=n_in-1`, else `i++` and go to X_RD.
- **WR**: write `out_base+n` with requant(acc). Go to DONE if `n=n_out-1`, else `n++`, `i=0`, and go to B_RD.
- **DONE**: `done=1` → IDLE.
- Requant: r = acc >>> OUT_SHIFT, then saturate to [-2^23, 2^23-1], then optional ReLU (see Configuration).
- `start` while not in IDLE is ignored.
- Reset mid-operation returns to IDLE immediately. No further RAM accesses occur; writes already completed remain in RAM.

## Timing
- Reset values: `busy`, `done`, `ram_en` = 0; `ram_we`, `ram_addr`, `ram_wdata` = 0; acc and counters = 0.
- `ram_en=0` in IDLE, B_CAP and DONE. In MAC, `ram_en=0` (no new command). All RAM outputs are registered.
- Per neuron: 3*n_in + 3 cycles.
- `busy` high for n_out*(3*n_in+3) + 1 cycles. `done` occurs in the last of these; `busy` falls together with `done` deasserting.
- A new `start` is accepted in the cycle after `done`.

## Configuration
- `DENSE_SEQ_RELU_EN` defined: negative saturated results are written as 0.
- `DENSE_SEQ_RELU_EN` undefined: the signed saturated value is written unchanged, as the output layer requires.

## Structure
- Package `dense_seq_pkg`: state enum, default ACC_WIDTH, and the `RAM_WE_ALL = 4'hF` constant.
- Sub-module `dense_seq_requant`: combinational shift, saturate and ReLU, parameterized by ACC_WIDTH, DATA_WIDTH and OUT_SHIFT.

## Test plan
- n_in=2, n_out=1, X=[3,4], W=[2,-1], b=5 → single write of 7 to `out_base`; `busy` high for 10 cycles.
- Same vectors with b=-20 (result -18) → writes 0 with `DENSE_SEQ_RELU_EN` defined, 24'hFFFFEE without it.
- b=24'h7FFFFF, X=[255], W=[1] → writes 24'h7FFFFF (saturated). b=24'h800000, W=[-1] → writes 24'h800000 without ReLU.
- n_out=0 → `done` one cycle after `start` with no RAM access. n_in=0, n_out=2, b=[9,-3] → writes 9 and then 0 (ReLU on), with `busy` lasting 7 cycles.
- OUT_SHIFT=8, acc=-1 → r=-1 → written as 0 (ReLU on) or 24'hFFFFFF (ReLU off). n_in=3, n_out=2 → the second neuron reads `w_base+3..w_base+5`.
- `start` pulsed mid-run is ignored. `rst_n` low mid-MAC → `busy=0`, `ram_en=0` in the same cycle, and no write follows after release.

Source files
------------

// File: rtl/dense_seq_pkg.sv
// dense_seq_pkg: shared definitions for the dense layer sequencer.
//   state_e            - sequencer FSM states
//   DEFAULT_ACC_WIDTH  - default accumulator width (2*24+10)
//   RAM_WE_ALL         - full-word RAM write enable
package dense_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_B_RD,
    S_B_CAP,
    S_X_RD,
    S_W_RD,
    S_MAC,
    S_WR,
    S_DONE
  } state_e;

  localparam int unsigned DEFAULT_ACC_WIDTH = 58;
  localparam logic [3:0]  RAM_WE_ALL        = 4'hF;

endpackage

// File: rtl/dense_seq_requant.sv
// dense_seq_requant: combinational requantization of the accumulator.
//   acc_i  : signed accumulator value
//   data_o : (acc_i >>> OUT_SHIFT) saturated to the signed DATA_WIDTH range,
//            then clamped at zero when DENSE_SEQ_RELU_EN is defined.
// Optional feature macro: DENSE_SEQ_RELU_EN.
module dense_seq_requant #(
  parameter int unsigned ACC_WIDTH  = 58,
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned OUT_SHIFT  = 0
) (
  input  logic signed [ACC_WIDTH-1:0]  acc_i,
  output logic        [DATA_WIDTH-1:0] data_o
);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0]  shifted;
  logic        [DATA_WIDTH-1:0] sat;

  assign shifted = acc_i >>> OUT_SHIFT;

  always_comb begin
    sat = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      sat = SAT_MAX[DATA_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      sat = SAT_MIN[DATA_WIDTH-1:0];
    end
  end

`ifdef DENSE_SEQ_RELU_EN
  assign data_o = sat[DATA_WIDTH-1] ? '0 : sat;
`else
  assign data_o = sat;
`endif

endmodule

// File: rtl/dense_layer_sequencer.sv
// dense_layer_sequencer: runs one fully-connected layer over the single-port
// inference RAM (bias read, x/w walk with signed MAC, requantize, write back).
//   clk, rst_n             : clock, async active-low reset
//   start                  : start request (accepted only in IDLE)
//   x_base/w_base/b_base/out_base, n_in, n_out : layer config, latched at start
//   busy, done             : status; done is a one-cycle completion pulse
//   ram_en/ram_we/ram_addr/ram_wdata : registered RAM command
//   ram_rdata              : RAM read data, valid the cycle after a read
// Optional feature macro: DENSE_SEQ_RELU_EN (ReLU on written results).
module dense_layer_sequencer
  import dense_seq_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 14,
  parameter int unsigned DATA_WIDTH    = 24,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned ACC_WIDTH     = DEFAULT_ACC_WIDTH,
  parameter int unsigned OUT_SHIFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] x_base,
  input  logic [ADDRESS_WIDTH-1:0] w_base,
  input  logic [ADDRESS_WIDTH-1:0] b_base,
  input  logic [ADDRESS_WIDTH-1:0] out_base,
  input  logic [CNT_WIDTH-1:0]     n_in,
  input  logic [CNT_WIDTH-1:0]     n_out,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_en,
  output logic [3:0]               ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  input  logic [DATA_WIDTH-1:0]    ram_rdata
);

  state_e                   state_q, state_d;
  logic [CNT_WIDTH-1:0]     n_q, n_d, i_q, i_d;
  logic [CNT_WIDTH-1:0]     n_in_q, n_in_d, n_out_q, n_out_d;
  logic [ADDRESS_WIDTH-1:0] x_base_q, x_base_d, b_base_q, b_base_d;
  logic [ADDRESS_WIDTH-1:0] out_base_q, out_base_d;
  logic [ADDRESS_WIDTH-1:0] x_ptr_q, x_ptr_d, w_ptr_q, w_ptr_d;
  logic [DATA_WIDTH-1:0]    x_q, x_d;
  logic [ACC_WIDTH-1:0]     acc_q, acc_d;

  logic                     en_d;
  logic [3:0]               we_d;
  logic [ADDRESS_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0]    wdata_d;

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]           prod_ext;
  logic [DATA_WIDTH-1:0]          rq_data;

  assign prod     = $signed(x_q) * $signed(ram_rdata);
  assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};

  // Accumulator next value lives in its own process so the write data can be
  // requantized from it in the same cycle the final write command is formed.
  always_comb begin
    acc_d = acc_q;
    case (state_q)
      S_IDLE:  if (start) acc_d = '0;
      S_B_CAP: acc_d = {{(ACC_WIDTH-DATA_WIDTH){ram_rdata[DATA_WIDTH-1]}}, ram_rdata};
      S_MAC:   acc_d = acc_q + prod_ext;
      default: ;
    endcase
  end

  dense_seq_requant #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_SHIFT  (OUT_SHIFT)
  ) u_requant (
    .acc_i  (acc_d),
    .data_o (rq_data)
  );

  // RAM commands are formed on the transition into the state that owns them,
  // so the registered outputs are valid during that state.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    i_d        = i_q;
    n_in_d     = n_in_q;
    n_out_d    = n_out_q;
    x_base_d   = x_base_q;
    b_base_d   = b_base_q;
    out_base_d = out_base_q;
    x_ptr_d    = x_ptr_q;
    w_ptr_d    = w_ptr_q;
    x_d        = x_q;
    en_d       = 1'b0;
    we_d       = '0;
    addr_d     = ram_addr;
    wdata_d    = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (n_out == '0) begin
            state_d = S_DONE;
          end else begin
            n_in_d     = n_in;
            n_out_d    = n_out;
            x_base_d   = x_base;
            b_base_d   = b_base;
            out_base_d = out_base;
            x_ptr_d    = x_base;
            w_ptr_d    = w_base;
            n_d        = '0;
            i_d        = '0;
            state_d    = S_B_RD;
            en_d       = 1'b1;
            addr_d     = b_base;
          end
        end
      end
      S_B_RD: state_d = S_B_CAP;
      S_B_CAP: begin
        x_ptr_d = x_base_q;
        en_d    = 1'b1;
        if (n_in_q == '0) begin
          state_d = S_WR;
          we_d    = RAM_WE_ALL;
          addr_d  = out_base_q + ADDRESS_WIDTH'(n_q);
          wdata_d = rq_data;
        end else begin
          state_d = S_X_RD;
          addr_d  = x_base_q;
        end
      end
      S_X_RD: begin
        state_d = S_W_RD;
        en_d    = 1'b1;
        addr_d  = w_ptr_q;
      end
      S_W_RD: begin
        x_d     = ram_rdata;
        state_d = S_MAC;
      end
      S_MAC: begin
        x_ptr_d = x_ptr_q + ADDRESS_WIDTH'(1);
        w_ptr_d = w_ptr_q + ADDRESS_WIDTH'(1);
        en_d    = 1'b1;
        if (i_q == n_in_q - CNT_WIDTH'(1)) begin
          state_d = S_WR;
          we_d    = RAM_WE_ALL;
          addr_d  = out_base_q + ADDRESS_WIDTH'(n_q);
          wdata_d = rq_data;
        end else begin
          i_d     = i_q + CNT_WIDTH'(1);
          state_d = S_X_RD;
          addr_d  = x_ptr_d;
        end
      end
      S_WR: begin
        if (n_q == n_out_q - CNT_WIDTH'(1)) begin
          state_d = S_DONE;
        end else begin
          n_d     = n_q + CNT_WIDTH'(1);
          i_d     = '0;
          state_d = S_B_RD;
          en_d    = 1'b1;
          addr_d  = b_base_q + ADDRESS_WIDTH'(n_d);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      i_q        <= '0;
      n_in_q     <= '0;
      n_out_q    <= '0;
      x_base_q   <= '0;
      b_base_q   <= '0;
      out_base_q <= '0;
      x_ptr_q    <= '0;
      w_ptr_q    <= '0;
      x_q        <= '0;
      acc_q      <= '0;
      ram_en     <= 1'b0;
      ram_we     <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      i_q        <= i_d;
      n_in_q     <= n_in_d;
      n_out_q    <= n_out_d;
      x_base_q   <= x_base_d;
      b_base_q   <= b_base_d;
      out_base_q <= out_base_d;
      x_ptr_q    <= x_ptr_d;
      w_ptr_q    <= w_ptr_d;
      x_q        <= x_d;
      acc_q      <= acc_d;
      ram_en     <= en_d;
      ram_we     <= we_d;
      ram_addr   <= addr_d;
      ram_wdata  <= wdata_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_dense_layer_sequencer.sv
module tb_dense_layer_sequencer;
  import dense_seq_pkg::*;

  localparam int AW = 14;
  localparam int DW = 24;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] x_base = '0, w_base = '0, b_base = '0, out_base = '0;
  logic [CW-1:0] n_in = '0, n_out = '0;
  logic          busy, done, ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  logic [57:0]   rq_acc = '0;
  logic [DW-1:0] rq_out;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;
  wr_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int accesses = 0;
  int writes = 0;

  always #5 clk = ~clk;

  dense_layer_sequencer #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .CNT_WIDTH     (CW),
    .ACC_WIDTH     (58),
    .OUT_SHIFT     (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x_base    (x_base),
    .w_base    (w_base),
    .b_base    (b_base),
    .out_base  (out_base),
    .n_in      (n_in),
    .n_out     (n_out),
    .busy      (busy),
    .done      (done),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  dense_seq_requant #(
    .ACC_WIDTH  (58),
    .DATA_WIDTH (DW),
    .OUT_SHIFT  (8)
  ) u_rq8 (
    .acc_i  (rq_acc),
    .data_o (rq_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef DENSE_SEQ_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // RAM model and write scoreboard
  always @(posedge clk) begin
    if (rst_n && ram_en) begin
      accesses++;
      if (ram_we == RAM_WE_ALL) begin
        writes++;
        mem[ram_addr] <= ram_wdata;
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_write observed=%0h@%0h expected=none", ram_wdata, ram_addr);
        end
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 64'(ram_addr), 64'(e.addr));
          chk("wr_data", 64'(ram_wdata), 64'(e.data));
        end
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic run_layer(input logic [AW-1:0] xb, wb, bb, ob,
                           input int ni, no, exp_busy, exp_acc,
                           input bit mid_start, input string tag);
    int cyc, dn, dn_last;
    accesses = 0;
    writes = 0;
    @(negedge clk);
    x_base = xb; w_base = wb; b_base = bb; out_base = ob;
    n_in = CW'(ni); n_out = CW'(no);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble config after start to show it was latched.
    x_base = AW'($urandom); w_base = AW'($urandom); b_base = AW'($urandom);
    out_base = AW'($urandom); n_in = '0; n_out = '0;
    cyc = 0; dn = 0; dn_last = 0;
    while (busy && cyc < 300) begin
      cyc++;
      if (done) begin
        dn++;
        dn_last = cyc;
      end
      start = (mid_start && cyc == 4);
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(cyc), 64'(exp_busy));
    chk({tag, "_done_count"}, 64'(dn), 64'd1);
    chk({tag, "_done_last"}, 64'(dn_last), 64'(cyc));
    chk({tag, "_ram_accesses"}, 64'(accesses), 64'(exp_acc));
    chk({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ram_en", 64'(ram_en), 64'd0);
    chk("rst_ram_we", 64'(ram_we), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_ram_wdata", 64'(ram_wdata), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: X=[3,4], W=[2,-1], b=5 -> 7
    mem[14'h100] = 24'd3; mem[14'h101] = 24'd4;
    mem[14'h200] = 24'd2; mem[14'h201] = 24'hFFFFFF;
    mem[14'h300] = 24'd5;
    exp_q.push_back('{14'h400, 24'd7});
    run_layer(14'h100, 14'h200, 14'h300, 14'h400, 2, 1, 10, 6, 1'b0, "t1");

    // T2: b=-20 -> -18
    mem[14'h300] = 24'hFFFFEC;
    exp_q.push_back('{14'h410, relu(24'hFFFFEE)});
    run_layer(14'h100, 14'h200, 14'h300, 14'h410, 2, 1, 10, 6, 1'b0, "t2");

    // T3: positive saturation
    mem[14'h120] = 24'd255; mem[14'h220] = 24'd1; mem[14'h320] = 24'h7FFFFF;
    exp_q.push_back('{14'h420, 24'h7FFFFF});
    run_layer(14'h120, 14'h220, 14'h320, 14'h420, 1, 1, 7, 4, 1'b0, "t3");

    // T4: negative saturation
    mem[14'h221] = 24'hFFFFFF; mem[14'h321] = 24'h800000;
    exp_q.push_back('{14'h421, relu(24'h800000)});
    run_layer(14'h120, 14'h221, 14'h321, 14'h421, 1, 1, 7, 4, 1'b0, "t4");

    // T5: n_out=0 -> done right away, no RAM traffic
    run_layer(14'h0, 14'h0, 14'h0, 14'h430, 5, 0, 1, 0, 1'b0, "t5");

    // T6: n_in=0, n_out=2, b=[9,-3]
    mem[14'h340] = 24'd9; mem[14'h341] = 24'hFFFFFD;
    exp_q.push_back('{14'h440, 24'd9});
    exp_q.push_back('{14'h441, relu(24'hFFFFFD)});
    run_layer(14'h0, 14'h0, 14'h340, 14'h440, 0, 2, 7, 4, 1'b0, "t6");

    // T7: n_in=3, n_out=2, continuous weight row, mid-run start ignored
    mem[14'h500] = 24'd10; mem[14'h501] = 24'd20; mem[14'h502] = 24'd30;
    mem[14'h600] = 24'd1;  mem[14'h601] = 24'hFFFFFE; mem[14'h602] = 24'd3;
    mem[14'h603] = 24'd4;  mem[14'h604] = 24'd5;      mem[14'h605] = 24'hFFFFFA;
    mem[14'h700] = 24'd100; mem[14'h701] = 24'hFFFFCE;
    exp_q.push_back('{14'h800, 24'd160});
    exp_q.push_back('{14'h801, relu(24'hFFFFA6)});
    run_layer(14'h500, 14'h600, 14'h700, 14'h800, 3, 2, 25, 16, 1'b1, "t7");

    // T8: reset during MAC
    accesses = 0;
    writes = 0;
    @(negedge clk);
    x_base = 14'h500; w_base = 14'h600; b_base = 14'h700; out_base = 14'h900;
    n_in = 16'd3; n_out = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t8_busy_in_reset", 64'(busy), 64'd0);
    chk("t8_ram_en_in_reset", 64'(ram_en), 64'd0);
    chk("t8_ram_we_in_reset", 64'(ram_we), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("t8_writes_after_reset", 64'(writes), 64'd0);
    chk("t8_busy_after_reset", 64'(busy), 64'd0);

    // Requant with OUT_SHIFT=8
    rq_acc = '1; #1;
    chk("rq8_minus1", 64'(rq_out), 64'(relu(24'hFFFFFF)));
    rq_acc = 58'h500; #1;
    chk("rq8_pos", 64'(rq_out), 64'd5);
    rq_acc = 58'h100_0000_0000; #1;
    chk("rq8_sat", 64'(rq_out), 64'h7FFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
